dmem_responder: RTL and testbench

Data-memory responder: the target end of the core's dmem request interface. It accepts one read or write request at a time and serves it from an on-chip word array with byte-lane strobes. After a programmable wait it returns `dmem_resp_v` with read data. It sits at system level beside the core and drives `dmem_resp`/`dmem_resp_v` back into the core's memory stage.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_array.sv | 30 +++
 rtl/dmem_responder.sv | 131 +++++++++++++
 tb/tb_dmem_responder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states, request record, alignment helper.
package dmem_pkg;

    localparam int DMEM_LAT_W = 4;
    localparam int DMEM_XLEN  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    typedef struct packed {
        logic [DMEM_XLEN-1:0] adr;
        logic [DMEM_XLEN-1:0] data;
        logic [3:0]           strobe;
        logic                 is_write;
    } dmem_req_t;

    // Word access needs a word-aligned address; halfword (two-lane) access needs an even address.
    function automatic logic dmem_misaligned(input logic [1:0] adr_lo, input logic [3:0] strobe);
        logic two_lane;
        two_lane = ($countones(strobe) == 2);
        return ((strobe == 4'hF) && (adr_lo != 2'b00)) || (two_lane && adr_lo[0]);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: synchronous byte-lane write, combinational read by word index.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [IDX_W-1:0]     idx,
    input  logic [3:0]           be,
    input  logic [DMEM_XLEN-1:0] wdata,
    output logic [DMEM_XLEN-1:0] rdata
);

    logic [DMEM_XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Target end of the dmem request interface: one request at a time, programmable wait, registered response.
// Optional DMEM_RESP_ERR_EN adds resp_err for out-of-range or misaligned requests.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int xlen    = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            r_v,
    input  logic            w_v,
    input  logic [xlen-1:0] data_adr,
    input  logic [xlen-1:0] data_i,
    input  logic [3:0]      strobe,
    output logic [xlen-1:0] dmem_resp,
    output logic            dmem_resp_v
`ifdef DMEM_RESP_ERR_EN
    ,
    output logic            resp_err
`endif
);

    localparam int IDX_W = $clog2(DEPTH);

    dmem_state_t           state_q, state_d;
    logic [DMEM_LAT_W-1:0] cnt_q, cnt_d;
    dmem_req_t             req_q, req_d;
    logic [xlen-1:0]       resp_q, resp_d;
    logic                  resp_v_q, resp_v_d;
    logic                  err_q, err_d;

    dmem_req_t             req_in, src_req;
    logic                  req_err;
    logic                  arr_we;
    logic [DMEM_XLEN-1:0]  rd_data, resp_next;

    // In IDLE the live inputs address the array so LATENCY=0 can respond straight from the accept edge.
    always_comb begin
        req_in  = '{adr: data_adr, data: data_i, strobe: strobe, is_write: w_v};
        src_req = (state_q == IDLE) ? req_in : req_q;
    end

`ifdef DMEM_RESP_ERR_EN
    assign req_err  = (|src_req.adr[DMEM_XLEN-1:IDX_W+2]) ||
                      dmem_misaligned(src_req.adr[1:0], src_req.strobe);
    assign resp_err = err_q;
`else
    logic unused_bits;
    assign req_err     = 1'b0;
    assign unused_bits = ^{src_req.adr[DMEM_XLEN-1:IDX_W+2], src_req.adr[1:0], err_q};
`endif

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .idx   (src_req.adr[IDX_W+1:2]),
        .be    (src_req.strobe),
        .wdata (src_req.data),
        .rdata (rd_data)
    );

    assign resp_next = (src_req.is_write || req_err) ? '0 : rd_data;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        resp_d   = resp_q;
        resp_v_d = 1'b0;
        err_d    = err_q;
        arr_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (r_v || w_v) begin
                    req_d = req_in;
                    if (LATENCY == 0) begin
                        state_d  = RESP;
                        resp_v_d = 1'b1;
                        resp_d   = resp_next;
                        err_d    = req_err;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = DMEM_LAT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d  = RESP;
                    resp_v_d = 1'b1;
                    resp_d   = resp_next;
                    err_d    = req_err;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                // Write commits on the edge leaving RESP, so a following read sees it.
                arr_we  = req_q.is_write && !req_err;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            req_q    <= '0;
            resp_q   <= '0;
            resp_v_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            resp_q   <= resp_d;
            resp_v_q <= resp_v_d;
            err_q    <= err_d;
        end
    end

    assign dmem_resp   = resp_q;
    assign dmem_resp_v = resp_v_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 1, 0, 3) against a word-array model with response schedule.
module tb_dmem_responder;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r_v  [3];
    logic        w_v  [3];
    logic [31:0] adr  [3];
    logic [31:0] dat  [3];
    logic [3:0]  strb [3];
    logic [31:0] resp [3];
    logic        resp_v [3];
`ifdef DMEM_RESP_ERR_EN
    logic        resp_err [3];
`endif

    always #5 clk = ~clk;

    dmem_responder #(.xlen(32), .DEPTH(DEPTH), .LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .r_v(r_v[0]), .w_v(w_v[0]), .data_adr(adr[0]),
        .data_i(dat[0]), .strobe(strb[0]), .dmem_resp(resp[0]), .dmem_resp_v(resp_v[0])
`ifdef DMEM_RESP_ERR_EN
        , .resp_err(resp_err[0])
`endif
    );

    dmem_responder #(.xlen(32), .DEPTH(DEPTH), .LATENCY(0)) u_l0 (
        .clk(clk), .rst_n(rst_n), .r_v(r_v[1]), .w_v(w_v[1]), .data_adr(adr[1]),
        .data_i(dat[1]), .strobe(strb[1]), .dmem_resp(resp[1]), .dmem_resp_v(resp_v[1])
`ifdef DMEM_RESP_ERR_EN
        , .resp_err(resp_err[1])
`endif
    );

    dmem_responder #(.xlen(32), .DEPTH(DEPTH), .LATENCY(3)) u_l3 (
        .clk(clk), .rst_n(rst_n), .r_v(r_v[2]), .w_v(w_v[2]), .data_adr(adr[2]),
        .data_i(dat[2]), .strobe(strb[2]), .dmem_resp(resp[2]), .dmem_resp_v(resp_v[2])
`ifdef DMEM_RESP_ERR_EN
        , .resp_err(resp_err[2])
`endif
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          exp_cycle [3];
    logic [31:0] exp_data  [3];
    logic        exp_err   [3];
    logic [31:0] mem [int];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic logic model_err(input logic [31:0] a, input logic [3:0] s);
`ifdef DMEM_RESP_ERR_EN
        int n;
        n = $countones(s);
        return (a >= 32'(4 * DEPTH)) || ((s == 4'hF) && (a[1:0] != 2'b00)) || ((n == 2) && a[0]);
`else
        return (a === 32'hx) && (s === 4'hx);
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Every cycle: a pulse exactly where the schedule says, with the modelled data.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            check($sformatf("resp_v_%0d", k), 32'(resp_v[k]), 32'(cyc == exp_cycle[k]));
            if (cyc == exp_cycle[k]) begin
                check($sformatf("resp_%0d", k), resp[k], exp_data[k]);
`ifdef DMEM_RESP_ERR_EN
                check($sformatf("resp_err_%0d", k), 32'(resp_err[k]), 32'(exp_err[k]));
`endif
            end
        end
    end

    task automatic issue(input int k, input logic rv, input logic wv, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s, output logic [31:0] got);
        int          key;
        logic        e;
        logic [31:0] word;
        @(negedge clk);
        r_v[k] = rv; w_v[k] = wv; adr[k] = a; dat[k] = d; strb[k] = s;
        key  = k * DEPTH + int'((a >> 2) % DEPTH);
        e    = model_err(a, s);
        word = mem.exists(key) ? mem[key] : 32'h0;
        exp_cycle[k] = cyc + 1 + lat_of(k);
        exp_err[k]   = e;
        if (wv) begin
            exp_data[k] = '0;
            if (!e) begin
                for (int i = 0; i < 4; i++) if (s[i]) word[8*i +: 8] = d[8*i +: 8];
                mem[key] = word;
            end
        end else begin
            exp_data[k] = e ? 32'h0 : word;
        end
        repeat (lat_of(k) + 1) @(negedge clk);
        got = resp[k];
        r_v[k] = 1'b0; w_v[k] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] got;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            r_v[k] = 1'b0; w_v[k] = 1'b0; adr[k] = '0; dat[k] = '0; strb[k] = '0;
            exp_cycle[k] = -1; exp_data[k] = '0; exp_err[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_resp_v_%0d", k), 32'(resp_v[k]), 32'h0);
            check($sformatf("reset_resp_%0d", k), resp[k], 32'h0);
        end
        rst_n = 1'b1;

        // LATENCY=1: basic write/read, strobe merge, wrap, r_v+w_v, zero strobe, low address bits
        issue(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, got);
        check("w10_resp_zero", got, 32'h0);
        issue(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, got);
        check("r10_lit", got, 32'hDEADBEEF);
        issue(0, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, got);
        issue(0, 1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, got);
        issue(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, got);
        check("merge_lit", got, 32'h11BB33DD);
        issue(0, 1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, got);
        issue(0, 1'b0, 1'b1, 32'h1000, 32'h5, 4'hF, got);
        issue(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, got);
`ifdef DMEM_RESP_ERR_EN
        check("wrap_lit", got, 32'hCAFEF00D);
`else
        check("wrap_lit", got, 32'h5);
`endif
        issue(0, 1'b1, 1'b1, 32'h40, 32'h77, 4'hF, got);
        check("rw_both_resp_zero", got, 32'h0);
        issue(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, got);
        check("rw_both_lit", got, 32'h77);
        issue(0, 1'b0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'h0, got);
        issue(0, 1'b1, 1'b0, 32'h43, 32'h0, 4'h0, got);
        check("zero_strobe_lit", got, 32'h77);

        // LATENCY=1: write aborted by reset while the response pulse is up
        @(negedge clk);
        w_v[0] = 1'b1; adr[0] = 32'h10; dat[0] = 32'h0; strb[0] = 4'hF;
        exp_cycle[0] = cyc + 2; exp_data[0] = 32'h0; exp_err[0] = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("abort_resp_v_async", 32'(resp_v[0]), 32'h0);
        w_v[0] = 1'b0;
        exp_cycle[0] = -1;
        @(negedge clk);
        rst_n = 1'b1;
        issue(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, got);
        check("abort_resp_no_write", got, 32'hDEADBEEF);

        // LATENCY=0
        issue(1, 1'b0, 1'b1, 32'h8, 32'h0000ABCD, 4'hF, got);
        issue(1, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, got);
        check("l0_read_lit", got, 32'h0000ABCD);
        issue(1, 1'b0, 1'b1, 32'h8, 32'h00120000, 4'b1100, got);
        issue(1, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, got);
        check("l0_merge_lit", got, 32'h0012ABCD);
        repeat (3) @(negedge clk);

        // LATENCY=3: write aborted by reset while waiting
        issue(2, 1'b0, 1'b1, 32'h80, 32'h12345678, 4'hF, got);
        @(negedge clk);
        w_v[2] = 1'b1; adr[2] = 32'h80; dat[2] = 32'hFFFF0000; strb[2] = 4'hF;
        @(negedge clk);
        rst_n = 1'b0;
        w_v[2] = 1'b0;
        repeat (2) @(negedge clk);
        check("wait_abort_resp_v", 32'(resp_v[2]), 32'h0);
        check("wait_abort_resp", resp[2], 32'h0);
        rst_n = 1'b1;
        issue(2, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0, got);
        check("wait_abort_no_write", got, 32'h12345678);
        issue(2, 1'b0, 1'b1, 32'h84, 32'h9ABC0000, 4'b1000, got);
        issue(2, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0, got);
        check("l3_other_word_lit", got, 32'h12345678);

        repeat (6) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
